// File: rtl/adv7513_init_seq.sv
// ADV7513 HDMI transmitter bring-up: polls hot-plug status over an I2C wrapper,
// then writes a register table with per-entry retry on ack error.
module adv7513_init_seq #(
  parameter logic [6:0] CHIP_ADDR = 7'h39,
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] POLL_REG  = 8'h42,
  parameter logic [7:0] POLL_MASK = 8'h40,
  parameter int         POLL_GAP  = 1000,
  parameter int         RETRY_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_done,
  input  logic       i2c_ack_error,
  input  logic [7:0] i2c_data,
  output logic [6:0] i2c_chip_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_value,
  output logic       i2c_enable,
  output logic       i2c_is_read,
  output logic [3:0] tbl_index,
  input  logic [7:0] tbl_reg,
  input  logic [7:0] tbl_val,
  output logic       busy,
  output logic       ready,
  output logic       error
);

  localparam int RW = $clog2(RETRY_MAX + 2);

  typedef enum logic [3:0] {
    IDLE, POLL_REQ, POLL_ACK, POLL_WAIT, POLL_GAP_S,
    WR_REQ, WR_ACK, WR_WAIT, FINISH, FAIL
  } state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_idx, w_idx_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic [15:0]     r_gap, w_gap_nxt;
  logic            r_en, r_rd, r_busy, r_ready, r_error;
  logic [7:0]      r_reg, r_val;
  logic            w_en_d, w_rd_d, w_busy_d, w_ready_d, w_error_d;
  logic [7:0]      w_reg_d, w_val_d;
  logic            w_hpd;

  assign w_hpd = !i2c_ack_error && ((i2c_data & POLL_MASK) == POLL_MASK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_retry <= '0;
      r_gap   <= '0;
      r_en    <= 1'b0;
      r_rd    <= 1'b0;
      r_reg   <= '0;
      r_val   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      r_retry <= w_retry_nxt;
      r_gap   <= w_gap_nxt;
      r_en    <= w_en_d;
      r_rd    <= w_rd_d;
      r_reg   <= w_reg_d;
      r_val   <= w_val_d;
      r_busy  <= w_busy_d;
      r_ready <= w_ready_d;
      r_error <= w_error_d;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_idx_nxt   = r_idx;
    w_retry_nxt = r_retry;
    w_gap_nxt   = r_gap;
    case (r_state)
      IDLE, FINISH, FAIL: begin
        if (start) begin
          w_next      = POLL_REQ;
          w_idx_nxt   = '0;
          w_retry_nxt = '0;
        end
      end
      POLL_REQ:  if (i2c_done) w_next = POLL_ACK;
      POLL_ACK:  if (!i2c_done) w_next = POLL_WAIT;
      POLL_WAIT: begin
        if (i2c_done) begin
          w_gap_nxt = '0;
          w_next    = w_hpd ? WR_REQ : POLL_GAP_S;
        end
      end
      POLL_GAP_S: begin
        if (r_gap == 16'(POLL_GAP - 1)) begin
          w_gap_nxt = '0;
          w_next    = POLL_REQ;
        end else begin
          w_gap_nxt = r_gap + 16'd1;
        end
      end
      WR_REQ: if (i2c_done) w_next = WR_ACK;
      WR_ACK: if (!i2c_done) w_next = WR_WAIT;
      WR_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack_error) begin
            // Failing attempt number RETRY_MAX+1 gives up instead of retrying
            if (r_retry == RW'(RETRY_MAX)) begin
              w_next = FAIL;
            end else begin
              w_retry_nxt = r_retry + 1'b1;
              w_next      = WR_REQ;
            end
          end else begin
            w_retry_nxt = '0;
            if (r_idx == 4'(NUM_REGS - 1)) begin
              w_next = FINISH;
            end else begin
              w_idx_nxt = r_idx + 4'd1;
              w_next    = WR_REQ;
            end
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Request fields are reloaded every REQ cycle, so they are valid on the
  // same edge that raises i2c_enable and stay frozen through ACK/WAIT.
  always_comb begin
    w_en_d  = 1'b0;
    w_rd_d  = r_rd;
    w_reg_d = r_reg;
    w_val_d = r_val;
    case (r_state)
      POLL_REQ: begin
        w_en_d  = i2c_done;
        w_rd_d  = 1'b1;
        w_reg_d = POLL_REG;
        w_val_d = 8'h00;
      end
      WR_REQ: begin
        w_en_d  = i2c_done;
        w_rd_d  = 1'b0;
        w_reg_d = tbl_reg;
        w_val_d = tbl_val;
      end
      default: ;
    endcase
    w_busy_d  = !(w_next inside {IDLE, FINISH, FAIL});
    w_ready_d = (w_next == FINISH);
    w_error_d = (w_next == FAIL);
  end

  assign i2c_chip_addr = CHIP_ADDR;
  assign i2c_reg_addr  = r_reg;
  assign i2c_value     = r_val;
  assign i2c_enable    = r_en;
  assign i2c_is_read   = r_rd;
  assign tbl_index     = r_idx;
  assign busy          = r_busy;
  assign ready         = r_ready;
  assign error         = r_error;

endmodule

// File: tb/tb_adv7513_init_seq.sv
// Directed bench for adv7513_init_seq: behavioural I2C wrapper with 10-clock
// transactions and a scoreboard of expected {is_read, reg, value} requests.
module tb_adv7513_init_seq;

  localparam int NREG = 4;
  localparam int GAP  = 5;
  localparam int RMAX = 3;
  localparam int TXN  = 10;

  typedef logic [16:0] txn_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       i2c_done;
  logic       i2c_ack_error = 1'b0;
  logic [7:0] i2c_data = 8'h00;
  logic [6:0] i2c_chip_addr;
  logic [7:0] i2c_reg_addr, i2c_value;
  logic       i2c_enable, i2c_is_read;
  logic [3:0] tbl_index;
  logic [7:0] tbl_reg, tbl_val;
  logic       busy, ready, error;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_en    = 0;
  int   txn_done_cnt = 0;
  txn_t exp_q[$];
  logic [7:0] poll_q[$];
  int   rd_cyc[$];
  int   wr_cyc[$];

  logic       m_done_raw = 1'b1;
  logic       hold = 1'b0;
  int         m_cnt = 0;
  txn_t       m_txn = '0;
  logic [7:0] err_reg = 8'hFF;
  int         err_left = 0;

  assign i2c_done = m_done_raw & ~hold;
  assign tbl_reg  = 8'h20 + 8'(tbl_index);
  assign tbl_val  = 8'hA0 + 8'(tbl_index);

  adv7513_init_seq #(
    .CHIP_ADDR(7'h39), .NUM_REGS(NREG), .POLL_REG(8'h42),
    .POLL_MASK(8'h40), .POLL_GAP(GAP), .RETRY_MAX(RMAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .i2c_done(i2c_done), .i2c_ack_error(i2c_ack_error), .i2c_data(i2c_data),
    .i2c_chip_addr(i2c_chip_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_value(i2c_value), .i2c_enable(i2c_enable), .i2c_is_read(i2c_is_read),
    .tbl_index(tbl_index), .tbl_reg(tbl_reg), .tbl_val(tbl_val),
    .busy(busy), .ready(ready), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wrapper model + scoreboard consumer, evaluated away from the active edge.
  always @(negedge clk) begin
    if (i2c_enable) begin
      n_en++;
      if (i2c_is_read) rd_cyc.push_back(cyc);
      else             wr_cyc.push_back(cyc);
      chk("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("txn", {i2c_is_read, i2c_reg_addr, i2c_value}, exp_q.pop_front());
      chk("chip_addr", 32'(i2c_chip_addr), 32'h39);
      m_txn      = {i2c_is_read, i2c_reg_addr, i2c_value};
      m_done_raw = 1'b0;
      m_cnt      = TXN;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (reset && busy) chk("req_stable", {i2c_is_read, i2c_reg_addr, i2c_value}, m_txn);
        if (m_txn[16]) begin
          i2c_ack_error = 1'b0;
          i2c_data      = (poll_q.size() != 0) ? poll_q.pop_front() : 8'h40;
        end else begin
          i2c_data = 8'h00;
          if (m_txn[15:8] == err_reg && err_left != 0) begin
            i2c_ack_error = 1'b1;
            if (err_left > 0) err_left--;
          end else begin
            i2c_ack_error = 1'b0;
          end
        end
        m_done_raw = 1'b1;
        txn_done_cnt++;
      end
    end
  end

  task automatic push_rd();
    exp_q.push_back({1'b1, 8'h42, 8'h00});
  endtask

  task automatic push_wr(input int i);
    exp_q.push_back({1'b0, 8'h20 + 8'(i), 8'hA0 + 8'(i)});
  endtask

  task automatic push_all();
    push_rd();
    for (int i = 0; i < NREG; i++) push_wr(i);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (busy && k < budget);
    chk({tag, "_idle_timeout"}, 32'(busy), 0);
  endtask

  task automatic wait_en(input int target, input int budget);
    int k;
    k = 0;
    while (n_en < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_en_timeout", 32'(n_en >= target), 1);
  endtask

  task automatic wait_txn(input int target, input int budget);
    int k;
    k = 0;
    while (txn_done_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("wait_txn_timeout", 32'(txn_done_cnt >= target), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    32'(i2c_enable),   0);
    chk({tag, "_rd"},    32'(i2c_is_read),  0);
    chk({tag, "_reg"},   32'(i2c_reg_addr), 0);
    chk({tag, "_val"},   32'(i2c_value),    0);
    chk({tag, "_idx"},   32'(tbl_index),    0);
    chk({tag, "_busy"},  32'(busy),         0);
    chk({tag, "_ready"}, 32'(ready),        0);
    chk({tag, "_error"}, 32'(error),        0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, base;

    // Reset state and idle after release
    #1 chk_reset_outputs("por");
    chk("chip_const", 32'(i2c_chip_addr), 32'h39);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("idle_no_en", n_en, 0);
    chk("idle_busy", 32'(busy), 0);

    // HPD present, full table, start-to-enable latency of 2 clocks
    push_all();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("lat_edge1_en", 32'(i2c_enable), 0);
    chk("lat_edge1_busy", 32'(busy), 1);
    @(posedge clk);
    #1 chk("lat_edge2_en", 32'(i2c_enable), 1);
    @(posedge clk);
    #1 chk("en_one_clk", 32'(i2c_enable), 0);
    wait_idle("basic", 2000);
    chk("basic_ready", 32'(ready), 1);
    chk("basic_error", 32'(error), 0);
    chk("basic_idx", 32'(tbl_index), NREG - 1);
    chk("basic_sb_empty", exp_q.size(), 0);

    // Two polls without HPD; read-to-read = accept(1)+TXN(10)+GAP(5)+REQ(1) = 17,
    // last read to first write = 1+10+1 = 12
    poll_q = '{8'h00, 8'h00};
    rd_cyc.delete();
    wr_cyc.delete();
    push_rd();
    push_rd();
    push_all();
    pulse_start();
    wait_idle("poll", 3000);
    chk("poll_reads", rd_cyc.size(), 3);
    if (rd_cyc.size() >= 3 && wr_cyc.size() >= 1) begin
      chk("poll_gap01", rd_cyc[1] - rd_cyc[0], 17);
      chk("poll_gap12", rd_cyc[2] - rd_cyc[1], 17);
      chk("poll_to_wr", wr_cyc[0] - rd_cyc[2], 12);
    end
    chk("poll_ready", 32'(ready), 1);
    chk("poll_sb_empty", exp_q.size(), 0);

    // Entry 2 fails twice then succeeds
    err_reg  = 8'h22;
    err_left = 2;
    push_rd();
    push_wr(0); push_wr(1); push_wr(2); push_wr(2); push_wr(2); push_wr(3);
    pulse_start();
    wait_idle("retry", 3000);
    chk("retry_ready", 32'(ready), 1);
    chk("retry_idx", 32'(tbl_index), 3);
    chk("retry_errs_used", err_left, 0);
    chk("retry_sb_empty", exp_q.size(), 0);

    // Entry 1 always fails: RETRY_MAX+1 attempts then FAIL
    err_reg  = 8'h21;
    err_left = -1;
    push_rd();
    push_wr(0);
    for (int i = 0; i <= RMAX; i++) push_wr(1);
    pulse_start();
    wait_idle("fail", 3000);
    chk("fail_error", 32'(error), 1);
    chk("fail_ready", 32'(ready), 0);
    chk("fail_idx", 32'(tbl_index), 1);
    n0 = n_en;
    repeat (40) @(posedge clk);
    #1 chk("fail_no_en", n_en, n0);
    chk("fail_busy", 32'(busy), 0);
    chk("fail_sb_empty", exp_q.size(), 0);
    err_left = 0;

    // Asynchronous reset while the entry-2 write is in flight
    push_all();
    base = n_en;
    pulse_start();
    wait_en(base + 4, 2000);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    n0 = n_en;
    repeat (30) @(posedge clk);
    #1 chk("rst_no_reissue", n_en, n0);
    chk("rst_idle_busy", 32'(busy), 0);
    push_all();
    pulse_start();
    wait_idle("restart", 2000);
    chk("restart_ready", 32'(ready), 1);
    chk("restart_sb_empty", exp_q.size(), 0);

    // Start while busy is ignored; i2c_done low holds the write request back
    push_all();
    base = txn_done_cnt;
    pulse_start();
    wait_txn(base + 1, 2000);
    @(negedge clk);
    hold  = 1'b1;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 chk("held_en_low", 32'(i2c_enable), 0);
    end
    chk("held_busy", 32'(busy), 1);
    chk("held_idx", 32'(tbl_index), 0);
    @(negedge clk) hold = 1'b0;
    @(posedge clk);
    #1 chk("release_en", 32'(i2c_enable), 1);
    @(posedge clk);
    #1 chk("release_en_drop", 32'(i2c_enable), 0);
    wait_idle("held", 2000);
    chk("held_ready", 32'(ready), 1);
    chk("held_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adv7513_init_seq.md
ADV7513_INIT_SEQ -- requirements
Module: adv7513_init_seq

Interface
REQ-001 SHALL have parameter CHIP_ADDR, default 7'h39, the 7-bit I2C address of the HDMI transmitter.
REQ-002 SHALL have parameter NUM_REGS, default 16, the number of table entries written (1..16).
REQ-003 SHALL have parameter POLL_REG, default 8'h42, the register read while waiting for hot-plug.
REQ-004 SHALL have parameter POLL_MASK, default 8'h40, the bits that must all read 1 to end polling.
REQ-005 SHALL have parameter POLL_GAP, default 1000, the idle clocks between poll reads.
REQ-006 SHALL have parameter RETRY_MAX, default 3, the retries allowed per transaction on ack error.
REQ-007 SHALL have ports `clk  in  1` (sole clock) and `reset  in  1`, where reset is asynchronous and active-low.
REQ-008 SHALL have port `start  in  1`, a pulse that begins the init sequence.
REQ-009 SHALL have ports `i2c_done  in  1`, `i2c_ack_error  in  1` and `i2c_data  in  8`, the status and read data from the I2C wrapper.
REQ-010 SHALL have ports `i2c_chip_addr  out  7`, `i2c_reg_addr  out  8`, `i2c_value  out  8`, `i2c_enable  out  1` and `i2c_is_read  out  1`, the request to the I2C wrapper.
REQ-011 SHALL have port `tbl_index  out  4`, the current table entry.
REQ-012 SHALL have ports `tbl_reg  in  8` and `tbl_val  in  8`, the combinational table contents at tbl_index.
REQ-013 SHALL have ports `busy  out  1`, `ready  out  1` and `error  out  1`, the sequence status.

Function
REQ-014 SHALL implement states IDLE, POLL_REQ, POLL_ACK, POLL_WAIT, POLL_GAP, WR_REQ, WR_ACK, WR_WAIT, FINISH and FAIL.
REQ-015 SHALL leave IDLE, FINISH or FAIL on start=1 for POLL_REQ, clearing tbl_index, retry count, ready and error; start SHALL be ignored in every other state.
REQ-016 SHALL assert i2c_enable only in POLL_REQ and WR_REQ, for exactly one clock, and only when i2c_done=1; while i2c_done=0 it SHALL stay in the *_REQ state.
REQ-017 SHALL move from *_REQ to *_ACK after issuing i2c_enable; *_ACK waits for i2c_done=0 (request accepted) and then moves to *_WAIT.
REQ-018 SHALL use *_WAIT to wait for i2c_done=1 and sample i2c_ack_error and i2c_data on that clock.
REQ-019 SHALL hold i2c_chip_addr, i2c_reg_addr, i2c_value and i2c_is_read stable from *_REQ until the transaction ends in *_WAIT.
REQ-020 SHALL always drive i2c_chip_addr = CHIP_ADDR.
REQ-021 SHALL drive the poll transaction as i2c_is_read=1 with i2c_reg_addr=POLL_REG.
REQ-022 SHALL drive the write transaction as i2c_is_read=0 with i2c_reg_addr=tbl_reg and i2c_value=tbl_val.
REQ-023 SHALL, on a poll with no ack error and (i2c_data & POLL_MASK)==POLL_MASK, go to WR_REQ; otherwise it SHALL go to POLL_GAP.
REQ-024 SHALL count exactly POLL_GAP clocks in POLL_GAP with a 16-bit counter, then return to POLL_REQ.
REQ-025 SHALL poll indefinitely; poll ack errors SHALL NOT count as retries.
REQ-026 SHALL, on a write that ends with an ack error, increment the retry count and reissue the same entry via WR_REQ.
REQ-027 SHALL go to FAIL when the retry count would exceed RETRY_MAX, giving RETRY_MAX+1 attempts in total.
REQ-028 SHALL, on a successful write, clear the retry count; if tbl_index==NUM_REGS-1 it goes to FINISH, otherwise it increments tbl_index and goes to WR_REQ.
REQ-029 SHALL NOT wrap tbl_index past NUM_REGS-1.
REQ-030 SHALL drive busy=1 in every state except IDLE, FINISH and FAIL.
REQ-031 SHALL drive ready=1 only in FINISH and error=1 only in FAIL; both are registered and mutually exclusive.
REQ-032 SHALL register all outputs with no combinational path from an input to an output.
REQ-033 SHALL have a latency from start to the first i2c_enable of 2 clocks, given i2c_done=1.

Reset
REQ-034 SHALL, on reset=0, go to IDLE immediately (asynchronously) with i2c_enable=0, i2c_is_read=0, i2c_reg_addr=0, i2c_value=0, tbl_index=0, busy=0, ready=0, error=0, and retry and gap counters at 0.
REQ-035 SHALL, when reset is asserted mid-transaction, abandon the transaction; after release it SHALL wait in IDLE for start, with no request reissued automatically.

Verification
REQ-036 SHALL be verified by: HPD present (poll returns 8'h40), NUM_REGS=4, wrapper model with 10-clock transactions -> one read of 0x42, then four writes of tbl_reg/tbl_val for indices 0..3 in order, then ready=1, busy=0.
REQ-037 SHALL be verified by: poll returns 8'h00 twice then 8'h40, POLL_GAP=5 -> three reads, each pair separated by exactly 5 idle clocks plus handshake, then the writes begin.
REQ-038 SHALL be verified by: ack error on the entry-2 write for two attempts, then success -> entry 2 written 3 times, tbl_index advances to 3, ready=1 at the end.
REQ-039 SHALL be verified by: persistent ack error on entry 1 with RETRY_MAX=3 -> exactly 4 write attempts of entry 1, then error=1, busy=0, no further i2c_enable.
REQ-040 SHALL be verified by: reset=0 pulsed while in WR_WAIT on entry 2 -> all outputs at reset values in the same clock, and no i2c_enable until start, after which the sequence restarts from the poll at index 0.
REQ-041 SHALL be verified by: start pulsed while busy, and i2c_done held 0 in WR_REQ -> start ignored, i2c_enable held low until i2c_done=1, then a single-clock enable.
